// File: rtl/intr_pkg.sv
// Shared definitions for the platform interrupt controller.
//   ID_W         : width of an interrupt ID (0 = none, 1..31 = source index + 1)
//   ADDR_*       : word addresses of the register port
package intr_pkg;
  localparam int ID_W = 5;

  localparam logic [5:0] ADDR_ENABLE      = 6'h00;
  localparam logic [5:0] ADDR_THRESHOLD   = 6'h01;
  localparam logic [5:0] ADDR_CLAIM       = 6'h02;
  localparam logic [5:0] ADDR_MTIME_LO    = 6'h04;
  localparam logic [5:0] ADDR_MTIME_HI    = 6'h05;
  localparam logic [5:0] ADDR_MTIMECMP_LO = 6'h06;
  localparam logic [5:0] ADDR_MTIMECMP_HI = 6'h07;
  localparam logic [5:0] ADDR_PRIO_BASE   = 6'h20;
endpackage

// File: rtl/intr_arbiter.sv
// Combinational max-select over the candidate interrupt sources.
//   cand      : pending & enable, one bit per source
//   prio      : per-source priority (0 = never wins)
//   best_id   : ID (index + 1) of the winning source, 0 when nothing qualifies
//   best_prio : priority of the winner, 0 when nothing qualifies
module intr_arbiter
  import intr_pkg::*;
#(
  parameter int N_SRC  = 8,
  parameter int PRIO_W = 3
) (
  input  logic [N_SRC-1:0]             cand,
  input  logic [N_SRC-1:0][PRIO_W-1:0] prio,
  output logic [ID_W-1:0]              best_id,
  output logic [PRIO_W-1:0]            best_prio
);

  // Strict '>' keeps the earlier (lower-index) source on a tie, and starting
  // from 0 excludes priority-0 sources without a separate test.
  always_comb begin
    best_id   = '0;
    best_prio = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (cand[i] && (prio[i] > best_prio)) begin
        best_id   = ID_W'(i + 1);
        best_prio = prio[i];
      end
    end
  end

endmodule

// File: rtl/intr_ctrl.sv
// Platform interrupt controller: per-source gateway with claim/complete,
// prioritized external-interrupt arbitration and a 64-bit machine timer.
//   clk, rstn          : clock, synchronous active-low reset
//   src                : level interrupt requests from peripherals
//   req_valid/we/addr/wdata : single-cycle register port, always accepted
//   rsp_valid/rsp_rdata     : acknowledge and read data one cycle later
//   ext_intr           : registered external interrupt to the core
//   timer_intr         : registered (mtime >= mtimecmp) to the core
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC    = 8,
  parameter int PRIO_W   = 3,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_SRC-1:0] src,
  input  logic             req_valid,
  input  logic             req_we,
  input  logic [5:0]       req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  output logic [31:0]      rsp_rdata,
  output logic             ext_intr,
  output logic             timer_intr
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [N_SRC-1:0]             enable_q;
  logic [PRIO_W-1:0]            threshold_q;
  logic [N_SRC-1:0][PRIO_W-1:0] prio_q;
  logic [N_SRC-1:0]             pending_q;
  logic [N_SRC-1:0]             inserv_q;
  logic [63:0]                  mtime_q;
  logic [63:0]                  mtimecmp_q;
  logic [PRESC_W-1:0]           presc_q;

  logic [ID_W-1:0]   best_id;
  logic [PRIO_W-1:0] best_prio;

  logic             wr_en, rd_en, claim_en, complete_en, tick;
  logic [N_SRC-1:0] claim_mask, complete_mask, gate_set;
  logic [31:0]      rdata_c, mtime_lo_n, mtime_hi_n;

  assign wr_en       = req_valid & req_we;
  assign rd_en       = req_valid & ~req_we;
  assign claim_en    = rd_en && (req_addr == ADDR_CLAIM);
  assign complete_en = wr_en && (req_addr == ADDR_CLAIM);
  assign tick        = (presc_q == PRESC_W'(TICK_DIV - 1));

  intr_arbiter #(
    .N_SRC  (N_SRC),
    .PRIO_W (PRIO_W)
  ) u_arbiter (
    .cand      (pending_q & enable_q),
    .prio      (prio_q),
    .best_id   (best_id),
    .best_prio (best_prio)
  );

  // A claim only ever names a pending source and the gateway only sets
  // non-pending ones, so the two masks never touch the same bit.
  assign gate_set = src & ~pending_q & ~inserv_q;

  always_comb begin
    claim_mask    = '0;
    complete_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (claim_en && (best_id == ID_W'(i + 1)))
        claim_mask[i] = 1'b1;
      if (complete_en && (req_wdata[ID_W-1:0] == ID_W'(i + 1)))
        complete_mask[i] = 1'b1;
    end
  end

  // A software write to one half overrides that half's increment; the carry
  // produced by the low half still reaches an unwritten high half.
  always_comb begin
    mtime_lo_n = mtime_q[31:0];
    mtime_hi_n = mtime_q[63:32];
    if (tick) begin
      mtime_lo_n = mtime_q[31:0] + 32'd1;
      if (&mtime_q[31:0])
        mtime_hi_n = mtime_q[63:32] + 32'd1;
    end
    if (wr_en && (req_addr == ADDR_MTIME_LO)) mtime_lo_n = req_wdata;
    if (wr_en && (req_addr == ADDR_MTIME_HI)) mtime_hi_n = req_wdata;
  end

  always_comb begin
    rdata_c = '0;
    case (req_addr)
      ADDR_ENABLE:      rdata_c = 32'(enable_q);
      ADDR_THRESHOLD:   rdata_c = 32'(threshold_q);
      ADDR_CLAIM:       rdata_c = 32'(best_id);
      ADDR_MTIME_LO:    rdata_c = mtime_q[31:0];
      ADDR_MTIME_HI:    rdata_c = mtime_q[63:32];
      ADDR_MTIMECMP_LO: rdata_c = mtimecmp_q[31:0];
      ADDR_MTIMECMP_HI: rdata_c = mtimecmp_q[63:32];
      default: begin
        for (int i = 0; i < N_SRC; i++)
          if (req_addr == (ADDR_PRIO_BASE + 6'(i)))
            rdata_c = 32'(prio_q[i]);
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      enable_q    <= '0;
      threshold_q <= '0;
      prio_q      <= '0;
      pending_q   <= '0;
      inserv_q    <= '0;
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      presc_q     <= '0;
      ext_intr    <= 1'b0;
      timer_intr  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      if (wr_en) begin
        case (req_addr)
          ADDR_ENABLE:      enable_q          <= req_wdata[N_SRC-1:0];
          ADDR_THRESHOLD:   threshold_q       <= req_wdata[PRIO_W-1:0];
          ADDR_MTIMECMP_LO: mtimecmp_q[31:0]  <= req_wdata;
          ADDR_MTIMECMP_HI: mtimecmp_q[63:32] <= req_wdata;
          default: ;
        endcase
        for (int i = 0; i < N_SRC; i++)
          if (req_addr == (ADDR_PRIO_BASE + 6'(i)))
            prio_q[i] <= req_wdata[PRIO_W-1:0];
      end

      pending_q <= (pending_q & ~claim_mask) | gate_set;
      inserv_q  <= (inserv_q | claim_mask) & ~complete_mask;

      presc_q <= tick ? '0 : presc_q + PRESC_W'(1);
      mtime_q <= {mtime_hi_n, mtime_lo_n};

      ext_intr   <= (best_id != '0) && (best_prio > threshold_q);
      timer_intr <= (mtime_q >= mtimecmp_q);

      rsp_valid <= req_valid;
      rsp_rdata <= rd_en ? rdata_c : 32'd0;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;
  localparam int N        = 8;
  localparam int TICK_DIV = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic [N-1:0]  src;
  logic          req_valid, req_we;
  logic [5:0]    req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          ext_intr, timer_intr;

  intr_ctrl #(.N_SRC(N), .PRIO_W(3), .TICK_DIV(TICK_DIV)) u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .src        (src),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .ext_intr   (ext_intr),
    .timer_intr (timer_intr)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: state as the spec describes it, advanced once per edge.
  logic [N-1:0] m_en, m_pend, m_insv;
  int           m_thr;
  int           m_prio [N];
  logic [63:0]  m_mtime, m_cmp;
  int           m_cyc;
  logic         m_ext, m_tmr, m_rspv;
  logic [31:0]  m_rdata;

  task automatic model_reset();
    m_en = '0; m_pend = '0; m_insv = '0; m_thr = 0;
    for (int i = 0; i < N; i++) m_prio[i] = 0;
    m_mtime = '0; m_cmp = '1; m_cyc = 0;
    m_ext = 0; m_tmr = 0; m_rspv = 0; m_rdata = '0;
  endtask

  // Highest priority level first, then lowest index within that level.
  function automatic int m_best();
    for (int p = 7; p >= 1; p--)
      for (int i = 0; i < N; i++)
        if (m_pend[i] && m_en[i] && m_prio[i] == p) return i + 1;
    return 0;
  endfunction

  task automatic model_edge();
    int id, pr, a, cid;
    logic [63:0]  t;
    logic [31:0]  rd;
    logic [N-1:0] np, ni;
    if (!rstn) begin
      model_reset();
      return;
    end
    id = m_best();
    pr = (id != 0) ? m_prio[id-1] : 0;
    a  = int'(req_addr);
    rd = '0;
    if (req_valid && !req_we) begin
      case (a)
        0: rd = 32'(m_en);
        1: rd = m_thr;
        2: rd = id;
        4: rd = m_mtime[31:0];
        5: rd = m_mtime[63:32];
        6: rd = m_cmp[31:0];
        7: rd = m_cmp[63:32];
        default: if (a >= 32 && a < 32 + N) rd = m_prio[a-32];
      endcase
    end
    np = m_pend; ni = m_insv;
    if (req_valid && !req_we && a == 2 && id != 0) begin
      np[id-1] = 1'b0;
      ni[id-1] = 1'b1;
    end
    for (int i = 0; i < N; i++)
      if (src[i] && !m_pend[i] && !m_insv[i]) np[i] = 1'b1;
    t = m_mtime + ((m_cyc % TICK_DIV == TICK_DIV - 1) ? 64'd1 : 64'd0);
    m_ext  = (id != 0) && (pr > m_thr);
    m_tmr  = (m_mtime >= m_cmp);
    m_rspv = req_valid;
    m_rdata = rd;
    if (req_valid && req_we) begin
      case (a)
        0: m_en = req_wdata[N-1:0];
        1: m_thr = int'(req_wdata[2:0]);
        2: begin
          cid = int'(req_wdata[4:0]);
          if (cid >= 1 && cid <= N) ni[cid-1] = 1'b0;
        end
        4: t[31:0] = req_wdata;
        5: t[63:32] = req_wdata;
        6: m_cmp[31:0] = req_wdata;
        7: m_cmp[63:32] = req_wdata;
        default: if (a >= 32 && a < 32 + N) m_prio[a-32] = int'(req_wdata[2:0]);
      endcase
    end
    m_pend = np; m_insv = ni; m_mtime = t; m_cyc++;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("ext_intr", ext_intr, m_ext);
    chk("timer_intr", timer_intr, m_tmr);
    chk("rsp_valid", rsp_valid, m_rspv);
    if (m_rspv) chk("rsp_rdata", rsp_rdata, m_rdata);
  endtask

  task automatic wr(input logic [5:0] addr, input logic [31:0] data);
    req_valid = 1; req_we = 1; req_addr = addr; req_wdata = data;
    cyc();
    req_valid = 0; req_we = 0;
  endtask

  task automatic rd(input logic [5:0] addr, output logic [31:0] data);
    req_valid = 1; req_we = 0; req_addr = addr; req_wdata = '0;
    cyc();
    data = rsp_rdata;
    req_valid = 0;
  endtask

  initial begin
    logic [31:0] d;
    int n, r;
    rstn = 0; src = '0; req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0;
    model_reset();
    repeat (3) cyc();
    rstn = 1;

    rd(6'h06, d); chk("cmp_lo_reset", d, 32'hFFFF_FFFF);
    rd(6'h07, d); chk("cmp_hi_reset", d, 32'hFFFF_FFFF);
    chk("ext_reset", ext_intr, 0);
    chk("tmr_reset", timer_intr, 0);

    // Timer rise: mtime reaches 10 after 40 edges, flag one edge later.
    rstn = 0; cyc(); rstn = 1;
    wr(6'h06, 32'd10);
    wr(6'h07, 32'd0);
    n = 2;
    while (!timer_intr && n < 200) begin cyc(); n++; end
    chk("tmr_rise_cycle", n, 41);
    wr(6'h07, 32'hFFFF_FFFF);
    chk("tmr_hold", timer_intr, 1);
    wr(6'h06, 32'hFFFF_FFFF);
    chk("tmr_drop", timer_intr, 0);

    // Two equal-priority sources, lowest index claimed first.
    wr(6'h22, 3); wr(6'h25, 3); wr(6'h00, 32'h24); wr(6'h01, 0);
    src = 8'h24; cyc(); src = '0;
    chk("ext_t1", ext_intr, 0);
    cyc();
    chk("ext_t2", ext_intr, 1);
    rd(6'h02, d); chk("claim_a", d, 3);
    rd(6'h02, d); chk("claim_b", d, 6);
    rd(6'h02, d); chk("claim_none", d, 0);
    cyc(); cyc();
    chk("ext_dropped", ext_intr, 0);
    wr(6'h02, 3); wr(6'h02, 6);

    // Priority equal to threshold never raises ext_intr but is claimable.
    wr(6'h21, 3); wr(6'h00, 32'h02); wr(6'h01, 3);
    src = 8'h02;
    repeat (3) cyc();
    chk("thr_blocks", ext_intr, 0);
    rd(6'h02, d); chk("thr_claim", d, 2);
    src = '0;
    wr(6'h02, 2);

    // Held source: no re-pend while in service, re-pends after complete.
    wr(6'h01, 0); wr(6'h20, 1); wr(6'h00, 32'h01);
    src = 8'h01;
    cyc(); cyc();
    rd(6'h02, d); chk("claim_src0", d, 1);
    repeat (4) cyc();
    chk("no_repend", ext_intr, 0);
    rd(6'h02, d); chk("claim_empty", d, 0);
    wr(6'h02, 1);
    cyc(); cyc();
    chk("repend_ext", ext_intr, 1);
    src = '0;
    rd(6'h02, d); chk("claim_again", d, 1);
    wr(6'h02, 1);

    // Reset while a read is in flight drops the response.
    req_valid = 1; req_we = 0; req_addr = 6'h06; rstn = 0;
    cyc();
    chk("rsp_dropped", rsp_valid, 0);
    req_valid = 0; rstn = 1;

    // Low-half wrap carries into the high half.
    wr(6'h05, 0);
    wr(6'h04, 32'hFFFF_FFFF);
    repeat (TICK_DIV) cyc();
    rd(6'h05, d); chk("wrap_hi", d, 1);

    // Randomized traffic against the model.
    for (int k = 0; k < 4000; k++) begin
      src  = N'($urandom) & N'($urandom);
      rstn = ($urandom_range(0, 599) != 0);
      r = $urandom_range(0, 15);
      req_valid = (r < 12);
      req_we = 1;
      req_wdata = $urandom;
      case (r)
        0: req_addr = 6'h00;
        1: begin req_addr = 6'h01; req_wdata = $urandom_range(0, 3); end
        2, 3: begin req_addr = 6'(32 + $urandom_range(0, N - 1)); req_wdata = $urandom_range(0, 7); end
        4, 5, 6: begin req_we = 0; req_addr = 6'h02; end
        7: begin req_addr = 6'h02; req_wdata = $urandom_range(0, N + 2); end
        8: begin req_we = 0; req_addr = 6'($urandom_range(0, 63)); end
        9: begin
          req_addr = 6'(6 + $urandom_range(0, 1));
          req_wdata = (req_addr == 6'h06) ? m_mtime[31:0] + $urandom_range(0, 40) : m_mtime[63:32];
        end
        10: begin
          req_addr = 6'(4 + $urandom_range(0, 1));
          if (req_addr == 6'h05) req_wdata = $urandom_range(0, 2);
        end
        default: req_addr = 6'($urandom_range(0, 63));
      endcase
      cyc();
    end
    req_valid = 0; rstn = 1;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
